// File: rtl/mult_sched_pkg.sv
// Shared definitions for the shared-multiplier scheduler: state encoding,
// default geometry and a constant-foldable clog2 helper.
package mult_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_BUSY = BUSY,
        ST_SIGN = SIGN,
        ST_DONE = DONE
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// Round-robin priority pick: the first asserted request scanning ptr+1,
// ptr+2, ... (mod NUM_REQ). Purely combinational.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan from the slot after the last winner; first hit wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_scheduler.sv
// Shares one iterative signed shift-add multiplier between NUM_REQ clients.
// Magnitudes are multiplied unsigned over WIDTH steps and the sign is
// applied once at the end, so -2^(WIDTH-1) operands stay exact.
module mult_share_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        resp_valid,
    output logic [ID_W-1:0]             resp_id,
    output logic signed [2*WIDTH-1:0]   resp_result,
    input  logic                        resp_ready,
    output logic                        busy
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t                    state;
    state_t                    state_nxt;
    logic [ID_W-1:0]           ptr;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           grant_idx;
    logic                      grant_any;
    logic                      can_accept;
    logic                      accept;
    logic                      handshake;
    logic                      last_step;
    logic signed [WIDTH-1:0]   sel_a;
    logic signed [WIDTH-1:0]   sel_b;
    logic [2*WIDTH:0]          acc;
    logic [WIDTH-1:0]          mag_a;
    logic                      sign_q;
    logic [ID_W-1:0]           id_q;
    logic [CNT_W-1:0]          cnt;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                             input logic neg);
        return neg ? -$signed(m) : $signed(m);
    endfunction

    // One step on {carry, hi, lo}: add |a| into hi when lo[0] is set, then
    // shift the whole accumulator right by one.
    function automatic logic [2*WIDTH:0] shift_add_step(input logic [2*WIDTH:0] a_in,
                                                        input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, a_in[2*WIDTH-1:WIDTH]} + (a_in[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {1'b0, sum, a_in[WIDTH-1:1]};
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Grant is only exposed when a new operand pair can be taken this cycle.
    always_comb begin
        can_accept = (state == ST_IDLE) || ((state == ST_DONE) && resp_ready);
        req_ready  = can_accept ? grant : '0;
        accept     = can_accept && grant_any;
        handshake  = resp_valid && resp_ready;
        last_step  = (cnt == CNT_W'(WIDTH - 1));
        busy       = (state != ST_IDLE);
    end

    // Route the granted slot's operands to the capture registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic; DONE can chain straight into BUSY on a handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_DONE;
            ST_DONE: if (handshake) state_nxt = accept ? ST_BUSY : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Arbitration pointer and response channel; a reset drops any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= ID_W'(NUM_REQ - 1);
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            if (accept) ptr <= grant_idx;
            if (state == ST_SIGN) begin
                resp_valid  <= 1'b1;
                resp_id     <= id_q;
                resp_result <= apply_sign(acc[2*WIDTH-1:0], sign_q);
            end else if (handshake) begin
                resp_valid  <= 1'b0;
            end
        end
    end

    // Multiply datapath: capture magnitudes at accept, then iterate.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {1'b0, {WIDTH{1'b0}}, magnitude(sel_b)};
            mag_a  <= magnitude(sel_a);
            sign_q <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
            id_q   <= grant_idx;
            cnt    <= '0;
        end else if (state == ST_BUSY) begin
            acc    <= shift_add_step(acc, mag_a);
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule
